// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer in front of the multi-cycle data RAM.
// Define MEM_ARB_RR_EN for round-robin arbitration (default: port 0 priority).
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic [DW-1:0] rdata0,
  output logic          ack0,
  output logic          stall0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic [DW-1:0] rdata1,
  output logic          ack1,
  output logic          stall1,
  output logic          m_cs,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_din,
  input  logic [DW-1:0] m_dout,
  input  logic          m_ack
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic          grant;
  logic          h_we;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_din;
  logic          win;
  logic          start;

  assign start = (state == IDLE) & (req0 | req1);

`ifdef MEM_ARB_RR_EN
  // last = port granted most recently; a tie goes to the other one
  logic last;

  always_comb begin
    win = ~req0;
    if (req0 & req1)
      win = ~last;
  end

  always_ff @(posedge clk) begin
    if (rst)
      last <= 1'b1;
    else if (start)
      last <= win;
  end
`else
  always_comb win = ~req0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      grant  <= 1'b0;
      h_we   <= 1'b0;
      h_addr <= '0;
      h_din  <= '0;
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            grant  <= win;
            h_we   <= win ? we1 : we0;
            h_addr <= win ? addr1 : addr0;
            h_din  <= win ? wdata1 : wdata0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (m_ack) begin
            state <= DONE;
            if (grant)
              ack1 <= 1'b1;
            else
              ack0 <= 1'b1;
            if (!h_we && grant)
              rdata1 <= m_dout;
            if (!h_we && !grant)
              rdata0 <= m_dout;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // slave lines are driven only from the holding registers
  assign m_cs   = (state == BUSY);
  assign m_we   = m_cs & h_we;
  assign m_addr = h_addr;
  assign m_din  = h_din;

  assign stall0 = req0 & ~ack0;
  assign stall1 = req1 & ~ack1;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural RAM slave,
// per-port scoreboard queues of expected rdata at each ack.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic [31:0] rdata0, rdata1;
  logic        ack0, ack1, stall0, stall1;
  logic        m_cs, m_we, m_ack;
  logic [31:0] m_addr, m_din, m_dout;

  mem_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .rdata0(rdata0), .ack0(ack0), .stall0(stall0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .rdata1(rdata1), .ack1(ack1), .stall1(stall1),
    .m_cs(m_cs), .m_we(m_we), .m_addr(m_addr), .m_din(m_din),
    .m_dout(m_dout), .m_ack(m_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int          ack_order[$];
  logic [31:0] exp_rd[2];
  int          n_ack0 = 0;
  int          n_ack1 = 0;

  int          lat = 1;
  logic        stray = 1'b0;
  int          busy_run = 0;
  int          idle_run = 100;
  int          last_busy_len = 0;
  logic [31:0] b_addr, b_din, wr_addr, wr_data;
  logic        b_we;

  function automatic logic [31:0] data_for(input logic [31:0] a);
    return (a == 32'h4) ? 32'hDEADBEEF : (a ^ 32'hA5A5A5A5);
  endfunction

  // RAM slave model and ack scoreboard
  always @(negedge clk) begin
    if (rst) begin
      busy_run = 0;
      idle_run = 100;
      m_ack    = 1'b0;
    end else begin
      if (m_cs) begin
        checks++;
        if (busy_run == 0) begin
          if (idle_run < 2) begin
            errors++;
            $display("FAIL cs_gap idle=%0d need>=2", idle_run);
          end
          b_addr = m_addr;
          b_we   = m_we;
          b_din  = m_din;
        end else if (m_addr !== b_addr || m_we !== b_we || m_din !== b_din) begin
          errors++;
          $display("FAIL busy_hold addr=%h/%h we=%b/%b din=%h/%h",
                   m_addr, b_addr, m_we, b_we, m_din, b_din);
        end
        busy_run++;
        idle_run = 0;
      end else begin
        if (busy_run != 0) last_busy_len = busy_run;
        busy_run = 0;
        idle_run++;
      end
      m_ack  = m_cs ? (busy_run == lat) : stray;
      m_dout = data_for(m_addr);
      if (m_ack && m_cs && m_we) begin
        wr_addr = m_addr;
        wr_data = m_din;
      end
      if (ack0 && ack1) begin
        errors++;
        $display("FAIL both_acks ack0=%b ack1=%b", ack0, ack1);
      end
      if (ack0) begin
        logic [31:0] e;
        checks++;
        n_ack0++;
        ack_order.push_back(0);
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL stray_ack0 rdata0=%h none expected", rdata0);
        end else begin
          e = q0.pop_front();
          if (rdata0 !== e) begin
            errors++;
            $display("FAIL rdata0 got=%h exp=%h", rdata0, e);
          end
        end
      end
      if (ack1) begin
        logic [31:0] e;
        checks++;
        n_ack1++;
        ack_order.push_back(1);
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL stray_ack1 rdata1=%h none expected", rdata1);
        end else begin
          e = q1.pop_front();
          if (rdata1 !== e) begin
            errors++;
            $display("FAIL rdata1 got=%h exp=%h", rdata1, e);
          end
        end
      end
    end
  end

  task automatic run_txn(input int p, input logic w,
                         input logic [31:0] a, input logic [31:0] d,
                         output int lat_obs);
    int   n;
    logic got;
    logic st;
    if (!w) exp_rd[p] = data_for(a);
    if (p == 0) begin
      q0.push_back(exp_rd[0]);
      we0 = w; addr0 = a; wdata0 = d; req0 = 1'b1;
    end else begin
      q1.push_back(exp_rd[1]);
      we1 = w; addr1 = a; wdata1 = d; req1 = 1'b1;
    end
    n   = 0;
    got = 1'b0;
    while (!got && n < 300) begin
      @(posedge clk); #1;
      n++;
      got = (p == 0) ? ack0 : ack1;
      st  = (p == 0) ? stall0 : stall1;
      checks++;
      if (st !== !got) begin
        errors++;
        $display("FAIL stall%0d cyc=%0d got=%b exp=%b", p, n, st, !got);
      end
    end
    lat_obs = n;
    if (!got) begin
      errors++;
      $display("FAIL timeout%0d no ack after %0d cycles", p, n);
    end
    @(posedge clk); #1;
    got = (p == 0) ? ack0 : ack1;
    checks++;
    if (got !== 1'b0) begin
      errors++;
      $display("FAIL ack_pulse%0d got=%b exp=0", p, got);
    end
    if (p == 0) req0 = 1'b0;
    else        req1 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({m_cs, m_we, ack0, ack1, stall0, stall1} !== 6'b0 ||
        m_addr !== 32'h0 || m_din !== 32'h0 ||
        rdata0 !== 32'h0 || rdata1 !== 32'h0) begin
      errors++;
      $display("FAIL reset cs=%b we=%b ack=%b%b addr=%h din=%h rd=%h/%h exp=0",
               m_cs, m_we, ack0, ack1, m_addr, m_din, rdata0, rdata1);
    end
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_read();
    int l;
    lat = 3;
    run_txn(1, 1'b0, 32'h4, 32'h0, l);
    checks++;
    if (l != 4) begin
      errors++;
      $display("FAIL read_latency got=%0d exp=4", l);
    end
    checks++;
    if (last_busy_len != 3 || b_addr !== 32'h4) begin
      errors++;
      $display("FAIL read_busy len=%0d addr=%h exp=3/00000004", last_busy_len, b_addr);
    end
    checks++;
    if (rdata1 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL read_data got=%h exp=deadbeef", rdata1);
    end
  endtask

  task automatic test_write();
    int l;
    lat = 2;
    run_txn(0, 1'b1, 32'h10, 32'h12345678, l);
    checks++;
    if (l != 3) begin
      errors++;
      $display("FAIL write_latency got=%0d exp=3", l);
    end
    checks++;
    if (b_we !== 1'b1 || b_din !== 32'h12345678 || b_addr !== 32'h10) begin
      errors++;
      $display("FAIL write_bus we=%b din=%h addr=%h exp=1/12345678/10", b_we, b_din, b_addr);
    end
    checks++;
    if (wr_addr !== 32'h10 || wr_data !== 32'h12345678) begin
      errors++;
      $display("FAIL write_commit addr=%h data=%h", wr_addr, wr_data);
    end
    checks++;
    if (rdata0 !== 32'h0) begin
      errors++;
      $display("FAIL write_rdata0 got=%h exp=0", rdata0);
    end
  endtask

  task automatic test_priority();
    int l0, l1;
    int e0;
`ifdef MEM_ARB_RR_EN
    e0 = 1;
`else
    e0 = 0;
`endif
    lat = 2;
    ack_order.delete();
    fork
      run_txn(0, 1'b0, 32'h20, 32'h0, l0);
      run_txn(1, 1'b0, 32'h24, 32'h0, l1);
    join
    checks++;
    if (ack_order.size() != 2 || ack_order[0] != e0 || ack_order[1] != 1 - e0) begin
      errors++;
      $display("FAIL priority_order n=%0d first=%0d exp_first=%0d",
               ack_order.size(), ack_order.size() > 0 ? ack_order[0] : -1, e0);
    end
  endtask

  task automatic test_stray_ack();
    int a0, a1, l;
    stray = 1'b1;
    a0 = n_ack0;
    a1 = n_ack1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (m_cs !== 1'b0 || n_ack0 != a0 || n_ack1 != a1) begin
      errors++;
      $display("FAIL stray_idle cs=%b acks=%0d/%0d exp 0/0", m_cs, n_ack0 - a0, n_ack1 - a1);
    end
    lat = 2;
    run_txn(1, 1'b0, 32'h30, 32'h0, l);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (m_cs !== 1'b0 || n_ack0 != a0 || n_ack1 != a1 + 1) begin
      errors++;
      $display("FAIL stray_done cs=%b acks=%0d/%0d exp 0/1", m_cs, n_ack0 - a0, n_ack1 - a1);
    end
    checks++;
    if (rdata0 !== exp_rd[0] || rdata1 !== exp_rd[1]) begin
      errors++;
      $display("FAIL stray_rdata got=%h/%h exp=%h/%h", rdata0, rdata1, exp_rd[0], exp_rd[1]);
    end
    stray = 1'b0;
  endtask

  task automatic test_reset_mid();
    int a0, l;
    lat = 5;
    a0 = n_ack0;
    we0 = 1'b0; addr0 = 32'h40; req0 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (m_cs !== 1'b1) begin
      errors++;
      $display("FAIL abort_busy cs=%b exp=1", m_cs);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (m_cs !== 1'b0 || ack0 !== 1'b0 || rdata0 !== 32'h0) begin
      errors++;
      $display("FAIL abort cs=%b ack0=%b rdata0=%h exp 0/0/0", m_cs, ack0, rdata0);
    end
    req0 = 1'b0;
    rst = 1'b0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (n_ack0 != a0 || m_cs !== 1'b0) begin
      errors++;
      $display("FAIL abort_noack acks=%0d cs=%b exp 0/0", n_ack0 - a0, m_cs);
    end
    lat = 2;
    run_txn(1, 1'b0, 32'h8, 32'h0, l);
    checks++;
    if (l != 3 || rdata1 !== data_for(32'h8)) begin
      errors++;
      $display("FAIL after_abort lat=%0d rdata1=%h exp 3/%h", l, rdata1, data_for(32'h8));
    end
  endtask

  task automatic test_back_to_back();
    int exp_ord[4];
    int ok;
`ifdef MEM_ARB_RR_EN
    exp_ord = '{0, 1, 0, 1};
`else
    exp_ord = '{0, 0, 0, 0};
`endif
    lat = 1;
    ack_order.delete();
    fork
      begin
        int l;
        for (int i = 0; i < 4; i++)
          run_txn(0, 1'b0, 32'h100 + 32'(i * 4), 32'h0, l);
      end
      begin
        int l;
        for (int i = 0; i < 4; i++)
          run_txn(1, 1'b0, 32'h200 + 32'(i * 4), 32'h0, l);
      end
    join
    ok = (ack_order.size() == 8) ? 1 : 0;
    for (int i = 0; i < 4 && ok == 1; i++)
      if (ack_order[i] != exp_ord[i]) ok = 0;
    checks++;
    if (ok != 1) begin
      errors++;
      $display("FAIL b2b_order n=%0d got=%0d%0d%0d%0d exp=%0d%0d%0d%0d",
               ack_order.size(),
               ack_order.size() > 0 ? ack_order[0] : 9,
               ack_order.size() > 1 ? ack_order[1] : 9,
               ack_order.size() > 2 ? ack_order[2] : 9,
               ack_order.size() > 3 ? ack_order[3] : 9,
               exp_ord[0], exp_ord[1], exp_ord[2], exp_ord[3]);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_priority();
    test_stray_ack();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL leftover q0=%0d q1=%0d exp 0/0", q0.size(), q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
